keystone_frame_sequencer: RTL
=============================

Name: keystone_frame_sequencer

Overview:
- Frame-level controller for the keystone correction datapath.
- Watches the input AXI4-Stream video handshake and tracks the (x,y) pixel position.
- Shadows the homography coefficients and enable from the AXI-Lite register file, and applies them only at start-of-frame.
- Sequences datapath soft reset on SW_RESET and flags SOF/EOL framing errors, so coefficients never change mid-frame.

Parameters:
- FRAME_WIDTH, 1920, active pixels per line
- FRAME_HEIGHT, 1080, active lines per frame
- COORD_W, 12, width of x/y coordinate outputs
- DP_RESET_CYCLES, 4, cycles dp_reset_n stays low after sw_reset deasserts or aresetn releases
- C_S_AXI_DATA_WIDTH, 32, width of each coefficient

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- aclken  in  1  clock enable; when low, all state except reset holds
- sw_reset  in  1  software reset level (SW_RESET register)
- enable_keystone  in  1  requested enable (ENABLE_KEYSTONE register)
- cfg_h  in  8*C_S_AXI_DATA_WIDTH  packed {H32,H31,H23,H22,H21,H13,H12,H11}, H11 in LSBs
- cfg_update  in  1  one-cycle pulse: register file was written
- s_tvalid, s_tready, s_tuser, s_tlast  in  1 each  tapped input video stream handshake
- h_active  out  8*C_S_AXI_DATA_WIDTH  coefficients driven to the datapath
- keystone_active  out  1  enable driven to the datapath
- dp_reset_n  out  1  datapath soft reset, active-low
- cur_x, cur_y  out  COORD_W each  coordinate of the next expected beat
- in_frame  out  1  high while state is ACTIVE
- frame_done  out  1  one-cycle pulse after the last pixel of a frame
- err_sof, err_early_eol, err_late_eol  out  1 each  one-cycle error pulses

Behaviour:
- Definition: beat = s_tvalid & s_tready & aclken. The block never drives the stream; it only observes it.
- Reset (aresetn low at posedge):
  - State RESET_DP, reset counter 0.
  - h_active = identity: H11 = H22 = 32'h0100_0000, all others 0.
  - keystone_active 0, dp_reset_n 0, cur_x/cur_y 0, pending 0.
  - All pulses 0, shadow = identity, shadow_en 0.
- Shadow:
  - cfg_update captures cfg_h and enable_keystone into the shadow regs and sets pending.
  - A repeat update before SOF overwrites the shadow; the last write wins.
- RESET_DP state:
  - dp_reset_n 0; cur_x/cur_y held 0.
  - h_active/keystone_active loaded from the shadow every cycle; pending cleared.
  - Counter increments while sw_reset is low and resets to 0 while sw_reset is high.
  - Exit to WAIT_SOF in the cycle after the counter reaches DP_RESET_CYCLES-1. dp_reset_n goes 1 on the same edge.
- WAIT_SOF state:
  - Beat with s_tuser: if pending, h_active/keystone_active <= shadow and pending cleared. Then cur_x=1, cur_y=0, state ACTIVE.
  - Beat with s_tuser and s_tlast together: treated as an early EOL (err_early_eol pulses), cur_x=0, cur_y=1.
  - Beat without s_tuser is ignored; no error is flagged.
- ACTIVE state, per beat, highest priority first:
  1. s_tuser: err_sof pulses; treated as a fresh SOF (apply pending, cur_x=1, cur_y=0).
  2. Last pixel (cur_x=FRAME_WIDTH-1, cur_y=FRAME_HEIGHT-1): frame_done pulses next cycle, state WAIT_SOF, cur_x=cur_y=0. err_late_eol pulses if s_tlast is absent.
  3. s_tlast with cur_x != FRAME_WIDTH-1: err_early_eol, cur_x=0, cur_y+1.
  4. cur_x=FRAME_WIDTH-1 without s_tlast: err_late_eol, cur_x=0, cur_y+1.
  5. Otherwise cur_x+1, or wrap to cur_x=0, cur_y+1 on a correct EOL.
- cur_y never exceeds FRAME_HEIGHT-1. An early EOL on the last line ends the frame as in rule 2, with err_early_eol.
- sw_reset high in any state: next state RESET_DP, dp_reset_n 0 on the next edge, counters cleared, in-progress frame abandoned, no frame_done.
- Simultaneous events:
  - cfg_update in the same cycle as an SOF beat: the SOF applies the old shadow; the new value is captured and remains pending for the next SOF.
  - sw_reset together with a beat: sw_reset wins.
- Latency: all outputs are registered; they update on the edge that samples the causing beat, so they are visible 1 cycle after.
- aclken low: nothing advances, pulses deassert, cfg_update is ignored.

Optional Feature:
- KEYSTONE_SEQ_STATS_EN defined: adds outputs frame_count[15:0] and err_count[15:0].
  - frame_count increments on frame_done.
  - err_count increments by 1 per cycle in which any err_* pulses.
  - Both saturate at 16'hFFFF and clear on aresetn or sw_reset.
- Undefined: the ports and registers do not exist.

Test Plan (FRAME_WIDTH=4, FRAME_HEIGHT=3, DP_RESET_CYCLES=4):
- Release aresetn -> dp_reset_n low exactly 4 cycles, then 1. h_active[31:0]=32'h0100_0000, keystone_active 0.
- Clean 12-beat frame with tuser on beat 0 and tlast on beats 3,7,11 -> in_frame high from beat 0, one frame_done pulse after beat 11, no err_*, cur_x/cur_y back to 0.
- cfg_update with H13=32'h0000_0A00 and enable=1 at beat 5 -> h_active unchanged through the frame, updates on the next SOF beat. Same pulse coincident with that SOF -> applies one frame later.
- tlast on beat 2 -> err_early_eol; next beat has cur_x=0, cur_y=1. Omit tlast on beat 7 -> err_late_eol, cur_y wraps correctly.
- tuser at beat 6 -> err_sof, cur_x=1, cur_y=0, frame restarts; frame_done only after 11 further beats.
- sw_reset high for 3 cycles mid-frame -> dp_reset_n low for 3+4 cycles, no frame_done, pending shadow applied. With KEYSTONE_SEQ_STATS_EN, frame_count and err_count read 0.

Source files
------------

// File: rtl/keystone_frame_sequencer.sv
// Frame-level sequencer for the keystone datapath: pixel tracking, SOF-aligned coefficient shadowing, soft reset.
// Define KEYSTONE_SEQ_STATS_EN to add the saturating frame_count / err_count outputs.
module keystone_frame_sequencer #(
    parameter int FRAME_WIDTH        = 1920,
    parameter int FRAME_HEIGHT       = 1080,
    parameter int COORD_W            = 12,
    parameter int DP_RESET_CYCLES    = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            aclken,
    input  logic                            sw_reset,
    input  logic                            enable_keystone,
    input  logic [8*C_S_AXI_DATA_WIDTH-1:0] cfg_h,
    input  logic                            cfg_update,
    input  logic                            s_tvalid,
    input  logic                            s_tready,
    input  logic                            s_tuser,
    input  logic                            s_tlast,
    output logic [8*C_S_AXI_DATA_WIDTH-1:0] h_active,
    output logic                            keystone_active,
    output logic                            dp_reset_n,
    output logic [COORD_W-1:0]              cur_x,
    output logic [COORD_W-1:0]              cur_y,
    output logic                            in_frame,
    output logic                            frame_done,
    output logic                            err_sof,
    output logic                            err_early_eol,
    output logic                            err_late_eol
`ifdef KEYSTONE_SEQ_STATS_EN
    ,
    output logic [15:0]                     frame_count,
    output logic [15:0]                     err_count
`endif
);

    localparam int HW    = 8 * C_S_AXI_DATA_WIDTH;
    localparam int CNT_W = $clog2(DP_RESET_CYCLES) + 1;

    localparam logic [1:0] RESET_DP = 2'd0;
    localparam logic [1:0] WAIT_SOF = 2'd1;
    localparam logic [1:0] ACTIVE   = 2'd2;

    localparam logic [C_S_AXI_DATA_WIDTH-1:0] H_ONE  = C_S_AXI_DATA_WIDTH'(32'h0100_0000);
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] H_ZERO = '0;
    // Identity homography: only H11 and H22 are non-zero.
    localparam logic [HW-1:0] H_IDENTITY = {H_ZERO, H_ZERO, H_ZERO, H_ONE, H_ZERO, H_ZERO, H_ZERO, H_ONE};

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DP_RESET_CYCLES - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FRAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FRAME_HEIGHT - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   rst_cnt;
    logic [HW-1:0]      shadow_h;
    logic               shadow_en;
    logic               pending;

    logic               beat, sof_beat, take, x_last, y_last, apply;
    logic               ev_done, ev_early, ev_late, ev_sof_err;
    logic [COORD_W-1:0] px, py, nx, ny;

    assign in_frame = (state == ACTIVE);

    // An SOF beat is evaluated as pixel (0,0), so SOF+EOL and restart cases fall out of the pixel rules.
    always_comb begin
        beat       = s_tvalid & s_tready & aclken & ~sw_reset;
        sof_beat   = beat & s_tuser & ((state == WAIT_SOF) | (state == ACTIVE));
        take       = sof_beat | (beat & (state == ACTIVE));
        px         = sof_beat ? '0 : cur_x;
        py         = sof_beat ? '0 : cur_y;
        x_last     = (px == X_LAST);
        y_last     = (py == Y_LAST);
        ev_done    = take & y_last & (x_last | s_tlast);
        ev_early   = take & s_tlast & ~x_last;
        ev_late    = take & x_last & ~s_tlast;
        ev_sof_err = sof_beat & (state == ACTIVE);
        apply      = sof_beat & pending;
        nx         = px + 1'b1;
        ny         = py;
        if (ev_done) begin
            nx = '0;
            ny = '0;
        end else if (x_last | s_tlast) begin
            nx = '0;
            ny = py + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state           <= RESET_DP;
            rst_cnt         <= '0;
            dp_reset_n      <= 1'b0;
            cur_x           <= '0;
            cur_y           <= '0;
            h_active        <= H_IDENTITY;
            keystone_active <= 1'b0;
            shadow_h        <= H_IDENTITY;
            shadow_en       <= 1'b0;
            pending         <= 1'b0;
            frame_done      <= 1'b0;
            err_sof         <= 1'b0;
            err_early_eol   <= 1'b0;
            err_late_eol    <= 1'b0;
        end else begin
            frame_done    <= ev_done;
            err_sof       <= ev_sof_err;
            err_early_eol <= ev_early;
            err_late_eol  <= ev_late;
            if (aclken) begin
                if (sw_reset) begin
                    state      <= RESET_DP;
                    rst_cnt    <= '0;
                    dp_reset_n <= 1'b0;
                    cur_x      <= '0;
                    cur_y      <= '0;
                end else begin
                    case (state)
                        RESET_DP: begin
                            if (rst_cnt == CNT_LAST) begin
                                state      <= WAIT_SOF;
                                rst_cnt    <= '0;
                                dp_reset_n <= 1'b1;
                            end else begin
                                rst_cnt <= rst_cnt + 1'b1;
                            end
                        end
                        WAIT_SOF, ACTIVE: begin
                            if (take) begin
                                state <= ev_done ? WAIT_SOF : ACTIVE;
                                cur_x <= nx;
                                cur_y <= ny;
                            end
                        end
                        default: begin
                            state      <= RESET_DP;
                            dp_reset_n <= 1'b0;
                        end
                    endcase
                end
                if ((state == RESET_DP) || apply) begin
                    h_active        <= shadow_h;
                    keystone_active <= shadow_en;
                end
                // A write in the same cycle as the apply stays pending for the next SOF.
                if (cfg_update) begin
                    shadow_h  <= cfg_h;
                    shadow_en <= enable_keystone;
                    pending   <= 1'b1;
                end else if ((state == RESET_DP) || apply) begin
                    pending <= 1'b0;
                end
            end
        end
    end

`ifdef KEYSTONE_SEQ_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            frame_count <= '0;
            err_count   <= '0;
        end else if (aclken) begin
            if (sw_reset) begin
                frame_count <= '0;
                err_count   <= '0;
            end else begin
                if (ev_done && (frame_count != 16'hFFFF))
                    frame_count <= frame_count + 16'd1;
                if ((ev_early | ev_late | ev_sof_err) && (err_count != 16'hFFFF))
                    err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule
